// File: rtl/dec_lut_pkg.sv
// rtl/dec_lut_pkg.sv - shared types, defaults and power-of-ten table for the BCD decoder
package dec_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_DIGITS = 16;
  localparam int DEF_DPC        = 2;
  localparam int DEF_N_BITS     = 52;

  // Scale factors for one digit group; indexed by digits-per-cycle.
  localparam logic [13:0] POW10 [1:4] = '{14'd10, 14'd100, 14'd1000, 14'd10000};

endpackage

// File: rtl/dec_lut_group.sv
// rtl/dec_lut_group.sv - converts DPC packed BCD digits to binary and flags nibbles above 9
module dec_lut_group
  import dec_lut_pkg::*;
#(
  parameter int DPC = DEF_DPC,
  localparam int GW = $clog2(POW10[DPC])
) (
  input  logic [4*DPC-1:0] digits,
  output logic [GW-1:0]    value,
  output logic             bad
);

  logic [GW-1:0] tmp;
  logic [3:0]    d;

  // Horner form, MSD first; valid groups never exceed 10^DPC-1 so GW bits suffice.
  always_comb begin
    tmp = '0;
    d   = '0;
    bad = 1'b0;
    for (int i = DPC - 1; i >= 0; i--) begin
      d   = digits[4*i +: 4];
      tmp = tmp * GW'(10) + GW'(d);
      if (d > 4'd9) bad = 1'b1;
    end
  end

  assign value = tmp;

endmodule

// File: rtl/dec_lut_decoder_param.sv
// rtl/dec_lut_decoder_param.sv - iterative BCD-to-binary decoder, DPC digits per cycle
module dec_lut_decoder_param
  import dec_lut_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DPC        = DEF_DPC,
  parameter int N_BITS     = DEF_N_BITS,
  localparam int W_BITS    = 4 * NUM_DIGITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W_BITS-1:0] W,
  output logic              busy,
  output logic              found,
  output logic [N_BITS-1:0] N,
  output logic              overflow,
  output logic              err_digit
);

  localparam int G  = NUM_DIGITS / DPC;
  localparam int CW = $clog2(G) + 1;
  localparam int GW = $clog2(POW10[DPC]);
  localparam int PW = N_BITS + 15;

  state_t            state;
  logic [W_BITS-1:0] w_reg;
  logic [CW-1:0]     cnt;
  logic [N_BITS:0]   acc;
  logic              ovf_acc;
  logic              err_acc;

  logic [GW-1:0]     gval;
  logic              gbad;
  logic [PW-1:0]     prod;
  logic              ovf_next;
  logic              err_next;

  dec_lut_group #(.DPC(DPC)) u_group (
    .digits (w_reg[W_BITS-1 -: 4*DPC]),
    .value  (gval),
    .bad    (gbad)
  );

  // Wide product so any bit at or above N_BITS is visible to the sticky overflow.
  assign prod     = PW'(acc) * PW'(POW10[DPC]) + PW'(gval);
  assign ovf_next = ovf_acc | (|prod[PW-1:N_BITS]);
  assign err_next = err_acc | gbad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      found     <= 1'b0;
      N         <= '0;
      overflow  <= 1'b0;
      err_digit <= 1'b0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      err_acc   <= 1'b0;
      w_reg     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            found     <= 1'b0;
            N         <= '0;
            overflow  <= 1'b0;
            err_digit <= 1'b0;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            err_acc   <= 1'b0;
            w_reg     <= W;
            cnt       <= '0;
          end
        end
        ST_RUN: begin
          acc     <= prod[N_BITS:0];
          ovf_acc <= ovf_next;
          err_acc <= err_next;
          w_reg   <= w_reg << (4 * DPC);
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(G - 1)) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            found     <= 1'b1;
            err_digit <= err_next;
            overflow  <= ~err_next & ovf_next;
            N         <= err_next ? '0 : (ovf_next ? '1 : prod[N_BITS-1:0]);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dec_lut_decoder_param.md
DEC_LUT_DECODER_PARAM -- requirements
Module: dec_lut_decoder_param

Interface
REQ-001 Parameter NUM_DIGITS, default 16: number of BCD digits in W; legal range 2..20.
REQ-002 Parameter DPC, default 2: digits consumed per cycle; must divide NUM_DIGITS; legal values 1, 2, 4.
REQ-003 Parameter N_BITS, default 52: binary result width; legal range 8..64.
REQ-004 Derived constant W_BITS = 4*NUM_DIGITS and G = NUM_DIGITS/DPC; neither is user-overridable.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  request conversion of W; sampled on rising edge.
REQ-008 W  input  W_BITS  packed BCD, most significant digit in W[W_BITS-1 -: 4].
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 found  output  1  result valid; level, held until next accepted start or reset.
REQ-011 N  output  N_BITS  binary result.
REQ-012 overflow  output  1  decimal value of W >= 2^N_BITS; valid with found.
REQ-013 err_digit  output  1  some nibble of W > 9; valid with found.

Function
REQ-014 States IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after G RUN cycles; DONE->RUN on start.
REQ-015 start is accepted only in IDLE or DONE; start in RUN is ignored, with no effect on in-flight data.
REQ-016 On acceptance at edge k: W captured into internal register; accumulator cleared; found, overflow and err_digit cleared; busy=1 from edge k.
REQ-017 Each RUN cycle: acc = acc*10^DPC + value(next DPC digits, MSD first); 10^DPC from a LUT, not a generic multiplier.
REQ-018 Accumulator is N_BITS+1 bits plus a sticky overflow bit; once acc >= 2^N_BITS, overflow latches and further products do not clear it.
REQ-019 Latency: found=1 and busy=0 from edge k+G; (default G=8).
REQ-020 Result: err_digit=1 -> N=0, overflow=0; else overflow=1 -> N = all ones (saturate); else N = exact binary value.
REQ-021 err_digit takes priority over overflow; both are never 1 together.
REQ-022 W changes after acceptance have no effect on the result in flight.
REQ-023 Back-to-back: start held high in DONE starts a new conversion at the next edge; found drops at that edge.
REQ-024 N, overflow and err_digit are stable while found=1.

Reset
REQ-025 rst_n=0 asynchronously forces state IDLE, busy=0, found=0, N=0, overflow=0, err_digit=0, accumulator=0.
REQ-026 Reset asserted mid-RUN aborts the conversion; no found pulse follows reset release.
REQ-027 First start is accepted on the first rising edge with rst_n=1.

Structure
REQ-028 Package dec_lut_pkg holds the state enum, default parameter values and the POW10 constant table (10^1..10^4).
REQ-029 One combinational sub-module dec_lut_group converts DPC BCD digits to binary (width ceil(log2(10^DPC))) and flags any nibble > 9.
REQ-030 Top module holds the FSM, capture register, digit-group shift/index counter (width clog2(G)+1) and accumulator.

Verification
REQ-031 Defaults, W = BCD 4503599627370495, start 1 cycle -> found at edge k+8, N = 2^52-1, overflow=0, err_digit=0.
REQ-032 Defaults, W = BCD 4503599627370496 -> overflow=1, N = all ones, err_digit=0.
REQ-033 Defaults, W = BCD 0000000000000000 -> N=0; W with one nibble 0xA -> err_digit=1, N=0, overflow=0.
REQ-034 start pulsed again at k+3 during RUN with different W -> ignored; result matches first W at k+8.
REQ-035 rst_n low at k+4 -> all outputs 0 immediately; after release, no found until a new start; new conversion correct.
REQ-036 NUM_DIGITS=8, DPC=1, N_BITS=27, W = BCD 99999999 -> found at k+8, N = 99999999, overflow=0; sweep 1000 random BCD inputs against a reference model.
